// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int REGFILE_WIDTH    = 64;
    localparam int REGFILE_NREG     = 32;
    localparam int REGFILE_ZERO_IDX = 31;

    typedef logic [63:0] word_t;

    // Take new bytes where be is set, keep old bytes elsewhere.
    function automatic word_t byte_merge(input word_t old_w, input word_t new_w,
                                         input logic [7:0] be);
        word_t r;
        r = old_w;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: NREG:1 mux, zero/range masking, optional write bypass.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int NREG     = REGFILE_NREG,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = REGFILE_ZERO_IDX,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en,
    input  logic [AW-1:0]              rd_addr,
    input  logic [NREG-1:0][WIDTH-1:0] regs,
    input  logic                       wr_hit,
    input  logic [AW-1:0]              wr_addr,
    input  logic [WIDTH-1:0]           wr_merged,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid
);

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             vld_q;
    logic             in_range;
    logic             is_zero;

    // Sparse decode keeps out-of-range addresses from selecting anything.
    always_comb begin
        mux_out = '0;
        for (int r = 0; r < NREG; r++) begin
            if (rd_addr == AW'(r)) mux_out = regs[r];
        end
    end

    always_comb begin
        in_range = int'(rd_addr) < NREG;
        is_zero  = (ZERO_EN != 0) && (int'(rd_addr) == ZERO_IDX);
        data_d   = '0;
        if (in_range && !is_zero) begin
            if ((BYPASS != 0) && wr_hit && (wr_addr == rd_addr)) data_d = wr_merged;
            else                                                 data_d = mux_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= rd_en;
            if (rd_en) data_q <= data_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = vld_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: byte-masked writes, NRD registered read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int NREG     = REGFILE_NREG,
    parameter int NRD      = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = REGFILE_ZERO_IDX,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/8-1:0]        wr_be,
    input  logic [NRD-1:0]            rd_en,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][WIDTH-1:0] rd_data,
    output logic [NRD-1:0]            rd_valid
);

    logic [NREG-1:0][WIDTH-1:0] regs_q;
    logic [NREG-1:0][WIDTH-1:0] regs_d;
    logic [WIDTH-1:0]           wr_old;
    logic [WIDTH-1:0]           wr_merged;
    logic                       wr_hit;

    // A write lands only in range and never on the hardwired-zero register.
    always_comb begin
        wr_hit = wr_en && (int'(wr_addr) < NREG) &&
                 !((ZERO_EN != 0) && (int'(wr_addr) == ZERO_IDX));
        wr_old = '0;
        for (int r = 0; r < NREG; r++) begin
            if (wr_addr == AW'(r)) wr_old = regs_q[r];
        end
    end

    generate
        if (WIDTH == REGFILE_WIDTH) begin : g_merge64
            assign wr_merged = byte_merge(wr_old, wr_data, wr_be);
        end else begin : g_merge_gen
            always_comb begin
                wr_merged = wr_old;
                for (int k = 0; k < WIDTH/8; k++) begin
                    if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
                end
            end
        end
    endgenerate

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_addr == AW'(r)) regs_d[r] = wr_merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            rf_read_port #(
                .WIDTH    (WIDTH),
                .NREG     (NREG),
                .ZERO_EN  (ZERO_EN),
                .ZERO_IDX (ZERO_IDX),
                .BYPASS   (BYPASS)
            ) u_port (
                .clk       (clk),
                .reset     (reset),
                .rd_en     (rd_en[p]),
                .rd_addr   (rd_addr[p]),
                .regs      (regs_q),
                .wr_hit    (wr_hit),
                .wr_addr   (wr_addr),
                .wr_merged (wr_merged),
                .rd_data   (rd_data[p]),
                .rd_valid  (rd_valid[p])
            );
        end
    endgenerate

endmodule
